// File: rtl/hdc_pkg.sv
// -----------------------------------------------------------------------------
// hdc_pkg
// Shared definitions for the sparse-HDC encode path: controller state
// encoding and the default hypervector / level-code geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package hdc_pkg;

  // Default geometry
  localparam int HDC_D      = 10;  // hypervector width in bits
  localparam int HDC_QW     = 4;   // quantized level code width
  localparam int HDC_NLEVEL = 10;  // codes >= this are out of range

  // Controller state enumeration, kept as plain constants so that legacy
  // blocks comparing against raw 2-bit codes keep working.
  typedef logic [1:0] hdc_state_t;
  localparam hdc_state_t S_IDLE   = 2'd0;
  localparam hdc_state_t S_FETCH  = 2'd1;
  localparam hdc_state_t S_THRESH = 2'd2;
  localparam hdc_state_t S_OUT    = 2'd3;

endpackage

// File: rtl/hdc_bundle_acc.sv
// -----------------------------------------------------------------------------
// hdc_bundle_acc
// D per-bit bundle counters. Each enabled cycle adds one bound hypervector
// bit-wise; ge[i] reports cnt[i] >= thr from the registered counts.
// Ports:
//   clk, nrst        clock, synchronous active-low reset
//   clr              zero all counters (wins over add_en)
//   add_en, add_vec  add add_vec[i] into counter i
//   thr              compare threshold (already forced to >= 1 by caller)
//   ge               per-bit threshold compare result
// -----------------------------------------------------------------------------
module hdc_bundle_acc
  import hdc_pkg::*;
#(
  parameter int D  = HDC_D,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic          add_en,
  input  logic [D-1:0]  add_vec,
  input  logic [CW-1:0] thr,
  output logic [D-1:0]  ge
);

  logic [CW-1:0] cnt_q [D];
  logic [CW-1:0] cnt_d [D];

  // Next-count and threshold compare. The count can never exceed the number
  // of channels per frame, which the caller sizes CW to hold, so no wrap.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      if (clr) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (add_en) begin
        cnt_d[i] = cnt_q[i] + CW'(add_vec[i]);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      ge[i] = (cnt_q[i] >= thr);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < D; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hdc_encode_ctrl.sv
// -----------------------------------------------------------------------------
// hdc_encode_ctrl
// Encodes one frame of NCH quantized levels into a D-bit hypervector:
// fetch each channel's level vector, bind by rotating left by the channel
// index, bundle in per-bit counters, threshold, present on valid/ready.
// Ports:
//   clk, nrst                 clock, synchronous active-low reset
//   in_valid/in_ready         frame handshake; in_qlevels channel c at [c*QW +: QW]
//   thr                       bundle threshold (0 behaves as 1), sampled at accept
//   fetch_en/fetch_qlevel     request to the level fetch block
//   fetch_hv                  level hypervector, combinational same-cycle return
//   out_valid/out_ready       result handshake, out_hv and err_range held in OUT
//   err_range                 some channel level was >= NLEVEL
//   busy                      controller not idle
// All outputs are registered.
// -----------------------------------------------------------------------------
module hdc_encode_ctrl
  import hdc_pkg::*;
#(
  parameter int D      = HDC_D,
  parameter int NCH    = 8,
  parameter int QW     = HDC_QW,
  parameter int NLEVEL = HDC_NLEVEL,
  parameter int CW     = $clog2(NCH + 1)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NCH*QW-1:0] in_qlevels,
  input  logic [CW-1:0]   thr,
  output logic            fetch_en,
  output logic [QW-1:0]   fetch_qlevel,
  input  logic [D-1:0]    fetch_hv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [D-1:0]    out_hv,
  output logic            err_range,
  output logic            busy
);

  localparam int               CHW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0]   LAST_CH  = CHW'(NCH - 1);
  localparam logic [QW:0]      NLEVEL_W = (QW + 1)'(NLEVEL);

  hdc_state_t          state_q, state_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [NCH*QW-1:0]   q_q, q_d;
  logic [CW-1:0]       thr_q, thr_d;
  logic                err_q, err_d;
  logic [D-1:0]        out_hv_q, out_hv_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                fetch_en_q, fetch_en_d;
  logic [QW-1:0]       fetch_qlevel_q, fetch_qlevel_d;

  logic                acc_clr;
  logic                acc_add;
  logic [D-1:0]        add_vec;
  logic [D-1:0]        acc_ge;
  logic [CW-1:0]       thr_eff;
  logic                level_oor;
  logic [2*D-1:0]      rot_dbl;
  int                  rot_amt;

  // Bind: rotate the fetched vector left by ch mod D. Doubling the vector
  // turns the rotate into a plain shift; the upper half is the result.
  // Out-of-range levels are masked here as well, so a misbehaving fetch
  // block cannot leak bits into the bundle.
  always_comb begin
    rot_amt   = int'(ch_q) % D;
    rot_dbl   = {fetch_hv, fetch_hv} << rot_amt;
    level_oor = ({1'b0, fetch_qlevel_q} >= NLEVEL_W);
    if (level_oor) begin
      add_vec = {D{1'b0}};
    end else begin
      add_vec = rot_dbl[2*D-1:D];
    end
    if (thr_q == {CW{1'b0}}) begin
      thr_eff = CW'(1);
    end else begin
      thr_eff = thr_q;
    end
  end

  // Sequencer next-state and registered-output next values
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    q_d      = q_q;
    thr_d    = thr_q;
    err_d    = err_q;
    out_hv_d = out_hv_q;
    acc_clr  = 1'b0;
    acc_add  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_FETCH;
          q_d     = in_qlevels;
          thr_d   = thr;
          err_d   = 1'b0;
          ch_d    = {CHW{1'b0}};
          acc_clr = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        acc_add = 1'b1;
        if (level_oor) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (ch_q == LAST_CH) begin
          state_d = S_THRESH;
          ch_d    = {CHW{1'b0}};
        end else begin
          state_d = S_FETCH;
          ch_d    = ch_q + 1'b1;
        end
      end
      S_THRESH: begin
        out_hv_d = acc_ge;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state; the
    // fetch select is looked up with the next channel index and frame.
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
    fetch_en_d  = (state_d == S_FETCH);
    if (fetch_en_d) begin
      fetch_qlevel_d = q_d[ch_d*QW +: QW];
    end else begin
      fetch_qlevel_d = {QW{1'b0}};
    end
  end

  // Controller state and output registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      ch_q           <= {CHW{1'b0}};
      q_q            <= {(NCH*QW){1'b0}};
      thr_q          <= {CW{1'b0}};
      err_q          <= 1'b0;
      out_hv_q       <= {D{1'b0}};
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      fetch_en_q     <= 1'b0;
      fetch_qlevel_q <= {QW{1'b0}};
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      q_q            <= q_d;
      thr_q          <= thr_d;
      err_q          <= err_d;
      out_hv_q       <= out_hv_d;
      out_valid_q    <= out_valid_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      fetch_en_q     <= fetch_en_d;
      fetch_qlevel_q <= fetch_qlevel_d;
    end
  end

  hdc_bundle_acc #(
    .D  (D),
    .CW (CW)
  ) u_acc (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .add_vec (add_vec),
    .thr     (thr_eff),
    .ge      (acc_ge)
  );

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_hv       = out_hv_q;
  assign err_range    = err_q;
  assign fetch_en     = fetch_en_q;
  assign fetch_qlevel = fetch_qlevel_q;

endmodule

// File: doc/hdc_encode_ctrl.md
# hdc_encode_ctrl

Sequencing controller for the sparse-HDC level item memory. Accepts one frame of `NCH` quantized feature levels and walks the channels one per cycle. For each channel it drives the level-fetch lookup, binds the returned level hypervector to its channel by cyclic rotation, and bundles the bound vectors in per-bit counters. After the last channel it thresholds the counters into one encoded hypervector and presents it on a valid/ready output. Sits between the quantizer and the associative-search stage; it owns the fetch port's `en` and `qlevel` inputs.

## Interface
Parameters:
- `D`, 10 — hypervector width in bits
- `NCH`, 8 — channels per frame
- `QW`, 4 — quantized level width
- `NLEVEL`, 10 — number of valid levels; level codes `>= NLEVEL` are out of range
- `CW`, `$clog2(NCH+1)` — bundle counter and threshold width

Ports:
- `clk`  in  1  rising-edge clock
- `nrst`  in  1  reset: synchronous, active-low
- `in_valid`  in  1  frame offered
- `in_ready`  out  1  controller can accept a frame
- `in_qlevels`  in  `NCH*QW`  channel c level at bits `[c*QW +: QW]`
- `thr`  in  `CW`  bundle threshold, sampled at frame accept
- `fetch_en`  out  1  enable to level fetch
- `fetch_qlevel`  out  `QW`  level select to level fetch
- `fetch_hv`  in  `D`  level hypervector returned combinationally, same cycle
- `out_valid`  out  1  encoded hypervector available
- `out_ready`  in  1  consumer accepts
- `out_hv`  out  `D`  encoded hypervector
- `err_range`  out  1  frame contained a level `>= NLEVEL`; valid with `out_valid`
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, FETCH, THRESH, OUT.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`: latch `in_qlevels` and `thr`, clear counters, clear `err_range`, set `ch=0`, go to FETCH.
- **FETCH**
  - `fetch_en=1`, `fetch_qlevel=q[ch]`.
  - `b = rotl(fetch_hv, ch mod D)`; `cnt[i] += b[i]` for every bit.
  - If `q[ch] >= NLEVEL`, set `err_range`. The fetch returns zero for such a level, so that channel contributes nothing.
  - At `ch==NCH-1` go to THRESH; otherwise `ch++`.
- **THRESH**
  - `out_hv[i] = (cnt[i] >= max(thr,1))`. A `thr` of 0 is treated as 1.
  - Go to OUT.
- **OUT**
  - `out_valid=1`, with `out_hv` and `err_range` held stable.
  - On `out_ready` go to IDLE.
- Outside FETCH: `fetch_en=0`, `fetch_qlevel=0`.
- Counters saturate by construction: the maximum count is `NCH`, which fits in `CW` bits.
- Reset values: `in_ready=0` during the reset cycle, then 1 in IDLE. `out_valid=0`, `out_hv=0`, `err_range=0`, `busy=0`, `fetch_en=0`, `fetch_qlevel=0`, counters 0, `ch=0`.

## Timing
- Frame accepted on edge T0.
- FETCH occupies T0+1 … T0+NCH, one channel per cycle, in channel order 0…NCH-1.
- THRESH occupies T0+NCH+1. `out_valid` rises at T0+NCH+2.
- Minimum frame period is NCH+3 cycles: accept, NCH fetches, threshold, one OUT cycle. IDLE is re-entered after the OUT handshake, so no frame is accepted in the handshake cycle.
- `in_valid` arriving while `busy` is ignored; `in_ready` stays 0.
- `out_ready` held low stalls OUT indefinitely, with outputs stable.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. Partial counters are discarded and no output is produced for the aborted frame.

## Structure
- Shared package `hdc_pkg`: state enum (IDLE, FETCH, THRESH, OUT), default `D`, `QW`, `NLEVEL`.
- Sub-module `hdc_bundle_acc`: holds `D` per-bit counters with a clear input, an add-vector input and a threshold compare output. The FSM, channel counter, rotation and handshakes stay in `hdc_encode_ctrl`.

## Test plan
Common setup: bench wires the real level-fetch block with `im_hvs[i] = 1<<i`, and uses `D=10`, `NCH=8`.
- **Distinct bits:** all levels 0, `thr=1` → channel c sets bit c; `out_hv=10'h0FF`, `err_range=0`, `out_valid` exactly 10 cycles after accept.
- **Aligned bits:** levels c = `(10-c) mod 10` (0,9,8,7,6,5,4,3). Every channel maps to bit 0, so `cnt[0]=8`.
  - `thr=8` → `10'h001`.
  - `thr=9` → `10'h000`.
  - `thr=0` → `10'h001`.
- **Out-of-range level:** channel 3 level 12, others 0, `thr=1` → `out_hv=10'h0F7`, `err_range=1`. Next frame with all levels 0 → `err_range=0`.
- **Output backpressure:** hold `out_ready=0` for 5 cycles in OUT → `out_valid`, `out_hv` and `err_range` stable; a second `in_valid` is not accepted until the cycle after the handshake.
- **Reset mid-frame:** assert `nrst=0` during FETCH at `ch=4` → next cycle IDLE, `fetch_en=0`, `out_valid=0`. The following frame (all levels 0, `thr=1`) yields exactly `10'h0FF`, with no stale counts.
- **Back-to-back frames:** `in_valid` and `out_ready` held high → one result every 11 cycles; `fetch_qlevel` sequence matches `in_qlevels` channel order.
